// File: rtl/tennis_button_debouncer_if.sv
// Purpose: button-side and game-side signals of the two-channel button conditioner.
// Latency: none, this is wiring only.
// Backpressure: none; the buttons are free-running levels and the outputs are registered levels and pulses.
// Ports: btn_right/btn_left (raw buttons), *_level (debounced level),
//        *_press (one-cycle press pulse), *_trigger (stretched press for the game block).
interface tennis_button_debouncer_if;
  logic btn_right;
  logic btn_left;
  logic right_level;
  logic left_level;
  logic right_press;
  logic left_press;
  logic right_trigger;
  logic left_trigger;

  // The conditioner itself
  modport slave (
    input  btn_right, btn_left,
    output right_level, left_level, right_press, left_press,
           right_trigger, left_trigger
  );

  // Button source and game side
  modport master (
    output btn_right, btn_left,
    input  right_level, left_level, right_press, left_press,
           right_trigger, left_trigger
  );
endinterface

// File: rtl/tennis_button_debouncer.sv
// Purpose: synchronise, debounce and press-detect two push-buttons, and stretch each press for the slow game clock.
// Latency: level DEBOUNCE_CYCLES+1 edges after the raw change reaches s1; press/trigger one edge later.
// Backpressure: none; a press during a stretch reloads it, so the trigger stays high with no gap.
// Ports: clk, reset (sync, active-high); bus.slave carries btn_right/btn_left in and
//        *_level, *_press, *_trigger out. Index 0 of the internal vectors is right, 1 is left.
module tennis_button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_WIDTH       = 20,
  parameter int STRETCH_CYCLES  = 8_000_000,
  parameter int STRETCH_WIDTH   = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  tennis_button_debouncer_if.slave   bus
);

  localparam logic [CNT_WIDTH-1:0]     CNT_MAX   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [STRETCH_WIDTH-1:0] SCNT_LOAD = STRETCH_WIDTH'(STRETCH_CYCLES - 1);

  logic [1:0]               btn;
  logic [1:0]               s1;
  logic [1:0]               s2;
  logic [1:0]               lvl;
  logic [1:0]               lvl_d;
  logic [1:0]               press;
  logic [1:0]               trig;
  logic [1:0]               rise;
  logic [CNT_WIDTH-1:0]     cnt  [2];
  logic [STRETCH_WIDTH-1:0] scnt [2];

  assign btn  = {bus.btn_left, bus.btn_right};

  // The press is seen one edge after lvl rises; the trigger loads on that
  // same edge, so press and trigger rise together.
  assign rise = lvl & ~lvl_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      lvl   <= '0;
      lvl_d <= '0;
      press <= '0;
      trig  <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i]  <= '0;
        scnt[i] <= '0;
      end
    end else begin
      s1    <= btn;
      s2    <= s1;
      lvl_d <= lvl;
      press <= rise;
      for (int i = 0; i < 2; i++) begin
        // Any sample agreeing with the accepted level restarts the count,
        // so only an unbroken run of DEBOUNCE_CYCLES disagreeing samples
        // moves the level.
        if (s2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          lvl[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end

        // scnt holds the remaining high cycles after the current one.
        if (rise[i]) begin
          scnt[i] <= SCNT_LOAD;
          trig[i] <= 1'b1;
        end else if (scnt[i] != '0) begin
          scnt[i] <= scnt[i] - 1'b1;
        end else begin
          trig[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.right_level   = lvl[0];
  assign bus.left_level    = lvl[1];
  assign bus.right_press   = press[0];
  assign bus.left_press    = press[1];
  assign bus.right_trigger = trig[0];
  assign bus.left_trigger  = trig[1];

endmodule
